gray_count_decoder: RTL

Receive-side companion to the team's binary-to-Gray counter. Samples a Gray-coded count word, decodes it to binary through a registered pipeline, and reports the signed-free (modulo) step since the previous sample. Checks that consecutive samples differ in at most one bit and counts violations. Sits at the consumer end of a Gray-coded count bus, for example a pointer or position crossing between blocks.

---
 rtl/gray_count_decoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gray_count_decoder.sv
// gray_count_decoder
// Receive-side decoder for a Gray-coded count bus. Registers the incoming
// Gray word, decodes it to binary, reports the modulo step since the previous
// valid sample and flags (and counts) samples where more than one bit moved.
// Build option: define GRAY_SYNC_EN to place a two-flop synchronizer on
// gray_in/gray_valid ahead of the input register (latency 2 -> 4 cycles).
module gray_count_decoder #(
  parameter int DATA_WID    = 4,
  parameter int ERR_CNT_WID = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [DATA_WID-1:0]    gray_in,
  input  logic                   gray_valid,
  output logic [DATA_WID-1:0]    bin_out,
  output logic                   bin_valid,
  output logic [DATA_WID-1:0]    delta,
  output logic                   step_err,
  output logic [ERR_CNT_WID-1:0] err_cnt
);

  localparam logic [DATA_WID-1:0]    DATA_ZERO = {DATA_WID{1'b0}};
  localparam logic [DATA_WID-1:0]    DATA_ONE  = {{(DATA_WID-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_WID-1:0] CNT_ZERO  = {ERR_CNT_WID{1'b0}};
  localparam logic [ERR_CNT_WID-1:0] CNT_ONE   = {{(ERR_CNT_WID-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_WID-1:0] CNT_MAX   = {ERR_CNT_WID{1'b1}};

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [DATA_WID-1:0] gray2bin(input logic [DATA_WID-1:0] g);
    logic [DATA_WID-1:0] b;
    b[DATA_WID-1] = g[DATA_WID-1];
    for (int i = DATA_WID - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves a residue.
  function automatic logic multi_bit(input logic [DATA_WID-1:0] d);
    return |(d & (d - DATA_ONE));
  endfunction

  logic [DATA_WID-1:0]    front_gray_s;
  logic                   front_vld_s;
  logic [DATA_WID-1:0]    s1_gray_r;
  logic                   s1_vld_r;
  logic [DATA_WID-1:0]    prev_gray_r;
  logic [DATA_WID-1:0]    prev_bin_r;
  logic                   primed_r;
  logic [DATA_WID-1:0]    bin_out_r;
  logic                   bin_valid_r;
  logic [DATA_WID-1:0]    delta_r;
  logic                   step_err_r;
  logic [ERR_CNT_WID-1:0] err_cnt_r;
  logic [DATA_WID-1:0]    dec_bin_s;
  logic [DATA_WID-1:0]    delta_nxt_s;
  logic                   step_err_nxt_s;

`ifdef GRAY_SYNC_EN
  logic [DATA_WID-1:0] sync1_gray_r;
  logic [DATA_WID-1:0] sync2_gray_r;
  logic                sync1_vld_r;
  logic                sync2_vld_r;

  // Two-flop synchronizer on the incoming Gray word and its qualifier.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_gray_r <= DATA_ZERO;
      sync2_gray_r <= DATA_ZERO;
      sync1_vld_r  <= 1'b0;
      sync2_vld_r  <= 1'b0;
    end else begin
      sync1_gray_r <= gray_in;
      sync2_gray_r <= sync1_gray_r;
      sync1_vld_r  <= gray_valid;
      sync2_vld_r  <= sync1_vld_r;
    end
  end

  assign front_gray_s = sync2_gray_r;
  assign front_vld_s  = sync2_vld_r;
`else
  assign front_gray_s = gray_in;
  assign front_vld_s  = gray_valid;
`endif

  // Stage 1: capture the sample and its valid flag every cycle.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1_gray_r <= DATA_ZERO;
      s1_vld_r  <= 1'b0;
    end else begin
      s1_gray_r <= front_gray_s;
      s1_vld_r  <= front_vld_s;
    end
  end

  // Decode and compare against the previous sample; first sample after reset has no reference.
  always_comb begin
    dec_bin_s      = gray2bin(s1_gray_r);
    delta_nxt_s    = DATA_ZERO;
    step_err_nxt_s = 1'b0;
    if (s1_vld_r && primed_r) begin
      delta_nxt_s    = dec_bin_s - prev_bin_r;
      step_err_nxt_s = multi_bit(s1_gray_r ^ prev_gray_r);
    end else begin
      delta_nxt_s    = DATA_ZERO;
      step_err_nxt_s = 1'b0;
    end
  end

  // Stage 2: publish decoded value, step and error flag; hold results between samples.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      bin_out_r   <= DATA_ZERO;
      bin_valid_r <= 1'b0;
      delta_r     <= DATA_ZERO;
      step_err_r  <= 1'b0;
      prev_gray_r <= DATA_ZERO;
      prev_bin_r  <= DATA_ZERO;
      primed_r    <= 1'b0;
    end else if (s1_vld_r) begin
      bin_out_r   <= dec_bin_s;
      bin_valid_r <= 1'b1;
      delta_r     <= delta_nxt_s;
      step_err_r  <= step_err_nxt_s;
      prev_gray_r <= s1_gray_r;
      prev_bin_r  <= dec_bin_s;
      primed_r    <= 1'b1;
    end else begin
      bin_valid_r <= 1'b0;
      step_err_r  <= 1'b0;
    end
  end

  // Saturating error counter, updated on the same edge that raises step_err.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      err_cnt_r <= CNT_ZERO;
    end else if (step_err_nxt_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bin_out   = bin_out_r;
  assign bin_valid = bin_valid_r;
  assign delta     = delta_r;
  assign step_err  = step_err_r;
  assign err_cnt   = err_cnt_r;

endmodule
